// File: rtl/cla_carry_pipe.sv
// Two-stage pipelined carry-lookahead carry generator with valid/ready handshakes.
// Optional macro CLA_OVF_FLAG_EN registers the signed-overflow flag on ovf; otherwise ovf is tied to 0.
module cla_carry_pipe #(
  parameter int WIDTH = 32,
  parameter int GROUP = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] a_out,
  output logic [WIDTH-1:0] b_out,
  output logic [WIDTH-1:0] c_out,
  output logic             cout,
  output logic             ovf
);

  localparam int NG = WIDTH / GROUP;

  generate
    if (WIDTH % GROUP != 0) begin : g_cfg_check
      $error("cla_carry_pipe: WIDTH must be a multiple of GROUP");
    end
  endgenerate

  logic             s1_valid, s2_valid;
  logic             s1_adv, s2_adv;
  logic [WIDTH-1:0] s1_a, s1_b, s1_g, s1_p;
  logic             s1_cin;
  logic [NG-1:0]    s1_gg, s1_gp;

  logic [WIDTH-1:0] in_g, in_p;
  logic [NG-1:0]    in_gg, in_gp;
  logic [NG:0]      grp_c;
  logic [WIDTH-1:0] bit_c;

  assign s2_adv    = !s2_valid || out_ready;
  assign s1_adv    = !s1_valid || s2_adv;
  assign in_ready  = s1_adv;
  assign out_valid = s2_valid;

  assign in_g = a & b;
  assign in_p = a ^ b;

  // Group generate folds from the group LSB upward: G = g[j] | p[j] & G_below.
  always_comb begin
    in_gg = '0;
    in_gp = '0;
    for (int k = 0; k < NG; k++) begin
      for (int j = 0; j < GROUP; j++) begin
        in_gg[k] = in_g[k*GROUP+j] | (in_p[k*GROUP+j] & in_gg[k]);
      end
      in_gp[k] = &in_p[k*GROUP +: GROUP];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_a     <= '0;
      s1_b     <= '0;
      s1_g     <= '0;
      s1_p     <= '0;
      s1_cin   <= 1'b0;
      s1_gg    <= '0;
      s1_gp    <= '0;
    end else if (s1_adv) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_a   <= a;
        s1_b   <= b;
        s1_g   <= in_g;
        s1_p   <= in_p;
        s1_cin <= cin;
        s1_gg  <= in_gg;
        s1_gp  <= in_gp;
      end
    end
  end

  // Group carries ripple across groups, then bit carries ripple inside each group.
  always_comb begin
    grp_c    = '0;
    bit_c    = '0;
    grp_c[0] = s1_cin;
    for (int k = 0; k < NG; k++) begin
      grp_c[k+1] = s1_gg[k] | (s1_gp[k] & grp_c[k]);
    end
    for (int k = 0; k < NG; k++) begin
      for (int j = 0; j < GROUP; j++) begin
        if (j == 0) begin
          bit_c[k*GROUP] = grp_c[k];
        end else begin
          bit_c[k*GROUP+j] = s1_g[k*GROUP+j-1] | (s1_p[k*GROUP+j-1] & bit_c[k*GROUP+j-1]);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid <= 1'b0;
      a_out    <= '0;
      b_out    <= '0;
      c_out    <= '0;
      cout     <= 1'b0;
    end else if (s2_adv) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        a_out <= s1_a;
        b_out <= s1_b;
        c_out <= bit_c;
        cout  <= grp_c[NG];
      end
    end
  end

`ifdef CLA_OVF_FLAG_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf <= 1'b0;
    end else if (s2_adv && s1_valid) begin
      ovf <= bit_c[WIDTH-1] ^ grp_c[NG];
    end
  end
`else
  assign ovf = 1'b0;
`endif

endmodule

// File: tb/tb_cla_carry_pipe.sv
// Scoreboard bench for cla_carry_pipe: arithmetic reference model, queue of expected results,
// and a negedge monitor that checks every output transfer and output stability while stalled.
module tb_cla_carry_pipe;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] c;
    logic        cout;
    logic        ovf;
    logic [31:0] sum;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] a;
  logic [31:0] b;
  logic        cin;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] a_out;
  logic [31:0] b_out;
  logic [31:0] c_out;
  logic        cout;
  logic        ovf;

  int   checks = 0;
  int   passes = 0;
  int   outCount = 0;
  int   cycleCount = 0;
  int   runLen = 0;
  int   maxRun = 0;
  bit   randomReady = 0;
  bit   stallPrev = 0;
  logic [31:0] heldC;
  logic [63:0] heldAB;
  exp_t expQ[$];
  exp_t e;

  cla_carry_pipe #(.WIDTH(32), .GROUP(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .a_out     (a_out),
    .b_out     (b_out),
    .c_out     (c_out),
    .cout      (cout),
    .ovf       (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cycleCount++;

  // Carry into bit i is the bit of the true sum that differs from a^b; cout is the 33rd sum bit.
  function automatic exp_t refModel(input logic [31:0] av, input logic [31:0] bv, input logic cv);
    exp_t r;
    logic [32:0] s;
    s = {1'b0, av} + {1'b0, bv} + {32'd0, cv};
    r.a = av;
    r.b = bv;
    r.c = s[31:0] ^ av ^ bv;
    r.cout = s[32];
    r.sum = s[31:0];
`ifdef CLA_OVF_FLAG_EN
    r.ovf = (av[31] == bv[31]) && (s[31] != av[31]);
`else
    r.ovf = 1'b0;
`endif
    return r;
  endfunction

  task automatic checkOutput(input string name, input logic [127:0] actual, input logic [127:0] expected);
    checks++;
    if (actual === expected) begin
      passes++;
    end else begin
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  always @(posedge clk) begin
    #1;
    if (randomReady) out_ready = ($urandom_range(0, 3) != 0);
  end

  // Monitor and scoreboard: check output transfers, stall stability, and record input transfers.
  always @(negedge clk) begin
    if (rst_n) begin
      if (stallPrev) begin
        checkOutput("stall_hold_c", {96'd0, c_out}, {96'd0, heldC});
        checkOutput("stall_hold_ab", {64'd0, a_out, b_out}, {64'd0, heldAB});
      end
      if (out_valid) begin
        runLen++;
        if (runLen > maxRun) maxRun = runLen;
      end else begin
        runLen = 0;
      end
      if (out_valid && out_ready) begin
        outCount++;
        if (expQ.size() == 0) begin
          checkOutput("unexpected_output", 128'd1, 128'd0);
        end else begin
          e = expQ.pop_front();
          checkOutput("operands", {64'd0, a_out, b_out}, {64'd0, e.a, e.b});
          checkOutput("c_out", {96'd0, c_out}, {96'd0, e.c});
          checkOutput("cout", {127'd0, cout}, {127'd0, e.cout});
          checkOutput("ovf", {127'd0, ovf}, {127'd0, e.ovf});
          checkOutput("sum", {96'd0, a_out ^ b_out ^ c_out}, {96'd0, e.sum});
        end
      end
      stallPrev = out_valid && !out_ready;
      heldC = c_out;
      heldAB = {a_out, b_out};
      if (in_valid && in_ready) expQ.push_back(refModel(a, b, cin));
    end else begin
      stallPrev = 0;
      runLen = 0;
    end
  end

  // Present one transaction and hold it until accepted; returns #1 after the accepting edge.
  task automatic applyStimulus(input logic [31:0] av, input logic [31:0] bv, input logic cv);
    bit acc;
    int waitCycles;
    waitCycles = 0;
    a = av;
    b = bv;
    cin = cv;
    in_valid = 1'b1;
    forever begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
      if (acc) break;
      waitCycles++;
      if (waitCycles > 200) begin
        checkOutput("accept_timeout", 128'd0, 128'd1);
        break;
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic waitDrain();
    int n;
    n = 0;
    while ((expQ.size() != 0 || out_valid) && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    checkOutput("drain_empty", {96'd0, 32'(expQ.size())}, 128'd0);
  endtask

  function automatic logic [31:0] randOperand();
    case ($urandom_range(0, 5))
      0: return 32'hFFFF_FFFF;
      1: return 32'h7FFF_FFFF;
      2: return 32'h0000_0000;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    int startCycle;
    int startOut;
    int accepted;
    bit acc;
    rst_n = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    a = '0;
    b = '0;
    cin = 1'b0;
    #2;
    checkOutput("reset_out_valid", {127'd0, out_valid}, 128'd0);
    checkOutput("reset_data", {29'd0, a_out, b_out, c_out, cout, ovf}, 128'd0);
    #5;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("in_ready_after_reset", {127'd0, in_ready}, 128'd1);

    $display("[TB] latency and wrap-around");
    out_ready = 1'b1;
    a = 32'hFFFF_FFFF;
    b = 32'h0000_0001;
    cin = 1'b0;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    checkOutput("latency_edge1", {127'd0, out_valid}, 128'd0);
    @(posedge clk);
    #1;
    checkOutput("latency_edge2", {127'd0, out_valid}, 128'd1);
    checkOutput("wrap_c_out", {96'd0, c_out}, {96'd0, 32'hFFFF_FFFE});
    checkOutput("wrap_cout", {127'd0, cout}, 128'd1);
    checkOutput("wrap_ovf", {127'd0, ovf}, 128'd0);
    waitDrain();

    $display("[TB] directed boundary vectors");
    applyStimulus(32'h7FFF_FFFF, 32'h0000_0001, 1'b0);
    applyStimulus(32'h0000_000F, 32'h0000_0000, 1'b1);
    applyStimulus(32'h8000_0000, 32'h8000_0000, 1'b0);
    applyStimulus(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
    waitDrain();

    $display("[TB] back-to-back");
    maxRun = 0;
    startCycle = cycleCount;
    startOut = outCount;
    for (int i = 0; i < 8; i++) applyStimulus($urandom, $urandom, 1'($urandom_range(0, 1)));
    checkOutput("b2b_cycles", {96'd0, 32'(cycleCount - startCycle)}, 128'd8);
    waitDrain();
    checkOutput("b2b_outputs", {96'd0, 32'(outCount - startOut)}, 128'd8);
    checkOutput("b2b_out_valid_run", {96'd0, 32'(maxRun)}, 128'd8);

    $display("[TB] downstream stall");
    out_ready = 1'b0;
    startOut = outCount;
    accepted = 0;
    a = $urandom;
    b = $urandom;
    cin = 1'($urandom_range(0, 1));
    in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
      if (acc) begin
        accepted++;
        a = $urandom;
        b = $urandom;
        cin = 1'($urandom_range(0, 1));
      end
    end
    checkOutput("stall_accepted", {96'd0, 32'(accepted)}, 128'd2);
    checkOutput("stall_in_ready", {127'd0, in_ready}, 128'd0);
    in_valid = 1'b0;
    out_ready = 1'b1;
    waitDrain();
    checkOutput("stall_drained", {96'd0, 32'(outCount - startOut)}, 128'd2);

    $display("[TB] asynchronous reset with transactions in flight");
    applyStimulus($urandom, $urandom, 1'b1);
    applyStimulus($urandom, $urandom, 1'b0);
    #2;
    rst_n = 1'b0;
    expQ.delete();
    #1;
    checkOutput("async_reset_out_valid", {127'd0, out_valid}, 128'd0);
    checkOutput("async_reset_data", {29'd0, a_out, b_out, c_out, cout, ovf}, 128'd0);
    @(negedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    startOut = outCount;
    applyStimulus(32'h0000_00FF, 32'h0000_0001, 1'b0);
    waitDrain();
    checkOutput("post_reset_outputs", {96'd0, 32'(outCount - startOut)}, 128'd1);

    $display("[TB] randomized traffic with random backpressure");
    randomReady = 1'b1;
    for (int i = 0; i < 300; i++) begin
      applyStimulus(randOperand(), randOperand(), 1'($urandom_range(0, 1)));
      if ($urandom_range(0, 4) == 0) begin
        @(posedge clk);
        #1;
      end
    end
    randomReady = 1'b0;
    out_ready = 1'b1;
    waitDrain();

    $display("[TB] %0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
